// File: rtl/fpu_pkg.sv
// fpu_pkg: constants and helpers shared by the FPU normalize/round back end.
//   FP_* constants describe the IEEE-754 binary32 layout used on the output.
//   FLG_* give the bit positions inside the 3-bit {exception, overflow,
//   underflow} flag vectors.
package fpu_pkg;

    localparam int          FP_BIAS    = 127;
    localparam int          FP_EXP_MAX = 255;
    localparam logic [31:0] FP_QNAN    = 32'h7FC0_0000;
    localparam int          FP_EXP_W   = 8;
    localparam int          FP_FRAC_W  = 23;

    localparam int FLG_EXC = 2;
    localparam int FLG_OVF = 1;
    localparam int FLG_UDF = 0;

    // Assemble a binary32 word from its three fields.
    function automatic logic [31:0] fp_pack(
        input logic                 sign,
        input logic [FP_EXP_W-1:0]  exp,
        input logic [FP_FRAC_W-1:0] frac
    );
        return {sign, exp, frac};
    endfunction

endpackage

// File: rtl/fpu_round_norm_if.sv
// fpu_round_norm_if: input-beat and output-result handshake bundle.
//   in_*  : unnormalized sign/exponent/mantissa beat with valid/ready.
//   out_* : packed binary32 result and per-result flags with valid/ready.
//   master modport = producer of beats / consumer of results (arith side).
//   slave  modport = the normalize/round block itself.
interface fpu_round_norm_if #(
    parameter int BITS  = 32,
    parameter int EXP_W = 10,
    parameter int MAN_W = 28
);
    logic             in_valid;
    logic             in_ready;
    logic             in_sign;
    logic [EXP_W-1:0] in_exp;
    logic [MAN_W-1:0] in_man;
    logic             in_nan;
    logic             in_inf;
    logic             out_valid;
    logic             out_ready;
    logic [BITS-1:0]  out_result;
    logic [2:0]       out_flags;

    modport master (
        output in_valid, in_sign, in_exp, in_man, in_nan, in_inf, out_ready,
        input  in_ready, out_valid, out_result, out_flags
    );

    modport slave (
        input  in_valid, in_sign, in_exp, in_man, in_nan, in_inf, out_ready,
        output in_ready, out_valid, out_result, out_flags
    );
endinterface

// File: rtl/fpu_lzc.sv
// fpu_lzc: combinational 28-bit leading-zero counter.
//   data_i : value to scan, bit 27 is the most significant.
//   cnt_o  : number of zeros above the first set bit (28 when data_i == 0).
module fpu_lzc (
    input  logic [27:0] data_i,
    output logic [4:0]  cnt_o
);

    // Scan upward so the highest set bit is the last to write the count.
    always_comb begin
        cnt_o = 5'd28;
        for (int i = 0; i < 28; i++) begin
            cnt_o = data_i[i] ? 5'(27 - i) : cnt_o;
        end
    end

endmodule

// File: rtl/fpu_round_norm.sv
// fpu_round_norm: two-stage normalize + round-to-nearest-even + pack.
//   clk, rst_n   : clock and asynchronous active-low reset.
//   bus (slave)  : input beat {sign, exp, man, nan, inf} with valid/ready,
//                  output {result, flags} with valid/ready.
//   flag_clr     : clears the accumulated flags.
//   sticky_flags : OR of out_flags over all transferred results since clear.
// Stage 1 brings the hidden one to bit 26; stage 2 rounds, resolves special
// cases and registers the packed result.
module fpu_round_norm
    import fpu_pkg::*;
#(
    parameter int BITS  = 32,
    parameter int EXP_W = 10,
    parameter int MAN_W = 28
) (
    input  logic                clk,
    input  logic                rst_n,
    fpu_round_norm_if.slave     bus,
    input  logic                flag_clr,
    output logic [2:0]          sticky_flags
);

    // Internal exponent is one bit wider than the input so +1 / -26 never wrap.
    localparam int          IEXP_W  = 11;
    localparam logic [11:0] EXP_TOP = 12'(FP_EXP_MAX);

    logic              s2_en_s;
    logic              s1_en_s;
    logic              xfer_s;
    logic [4:0]        lzc_s;
    logic [4:0]        shamt_s;
    logic [IEXP_W-1:0] exp_ext_s;

    logic              s1_valid_q;
    logic              s1_sign_q,  s1_sign_d;
    logic [IEXP_W-1:0] s1_exp_q,   s1_exp_d;
    logic [26:0]       s1_man_q,   s1_man_d;
    logic              s1_zero_q,  s1_zero_d;
    logic              s1_nan_q,   s1_nan_d;
    logic              s1_inf_q,   s1_inf_d;

    logic              rnd_up_s;
    logic [24:0]       mant_sum_s;
    logic [11:0]       exp_rnd_s;
    logic [22:0]       frac_s;

    logic              out_valid_q;
    logic [BITS-1:0]   out_result_q, out_result_d;
    logic [2:0]        out_flags_q,  out_flags_d;
    logic [2:0]        sticky_q;

    assign s2_en_s      = !out_valid_q || bus.out_ready;
    assign s1_en_s      = !s1_valid_q || s2_en_s;
    assign xfer_s       = out_valid_q && bus.out_ready;
    assign bus.in_ready = s1_en_s;

    assign bus.out_valid  = out_valid_q;
    assign bus.out_result = out_result_q;
    assign bus.out_flags  = out_flags_q;
    assign sticky_flags   = sticky_q;

    fpu_lzc u_lzc (
        .data_i (bus.in_man),
        .cnt_o  (lzc_s)
    );

    // Stage 1 next state: move the leading one to bit 26 and adjust exponent.
    always_comb begin
        exp_ext_s = {{(IEXP_W-EXP_W){bus.in_exp[EXP_W-1]}}, bus.in_exp};
        // lzc counts from bit 27; bit 26 is the target, hence the -1.
        shamt_s   = lzc_s - 5'd1;
        s1_sign_d = bus.in_sign;
        s1_nan_d  = bus.in_nan;
        s1_inf_d  = bus.in_inf;
        s1_zero_d = (bus.in_man == {MAN_W{1'b0}});
        s1_man_d  = 27'd0;
        s1_exp_d  = exp_ext_s;
        if (bus.in_man[MAN_W-1]) begin
            // Carry: shift right one, the dropped bit stays visible as sticky.
            s1_man_d = {bus.in_man[27:2], bus.in_man[1] | bus.in_man[0]};
            s1_exp_d = exp_ext_s + 11'd1;
        end else if (s1_zero_d) begin
            s1_man_d = 27'd0;
            s1_exp_d = exp_ext_s;
        end else begin
            s1_man_d = bus.in_man[26:0] << shamt_s;
            s1_exp_d = exp_ext_s - {6'd0, shamt_s};
        end
    end

    // Stage 1 register: accept a beat whenever the stage is free or draining.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_sign_q  <= 1'b0;
            s1_exp_q   <= 11'd0;
            s1_man_q   <= 27'd0;
            s1_zero_q  <= 1'b0;
            s1_nan_q   <= 1'b0;
            s1_inf_q   <= 1'b0;
        end else if (s1_en_s) begin
            s1_valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                s1_sign_q <= s1_sign_d;
                s1_exp_q  <= s1_exp_d;
                s1_man_q  <= s1_man_d;
                s1_zero_q <= s1_zero_d;
                s1_nan_q  <= s1_nan_d;
                s1_inf_q  <= s1_inf_d;
            end
        end
    end

    // Stage 2 next state: round to nearest even, then resolve special cases.
    always_comb begin
        rnd_up_s   = s1_man_q[2] & (s1_man_q[3] | s1_man_q[1] | s1_man_q[0]);
        mant_sum_s = {1'b0, s1_man_q[26:3]} + {24'd0, rnd_up_s};
        exp_rnd_s  = {s1_exp_q[IEXP_W-1], s1_exp_q} + {11'd0, mant_sum_s[24]};
        // A carry out of the hidden bit leaves 10.000..., i.e. a zero fraction.
        frac_s     = mant_sum_s[24] ? mant_sum_s[23:1] : mant_sum_s[22:0];

        out_result_d = BITS'(32'd0);
        out_flags_d  = 3'b000;
        if (s1_nan_q) begin
            out_result_d         = FP_QNAN;
            out_flags_d[FLG_EXC] = 1'b1;
        end else if (s1_inf_q) begin
            out_result_d = fp_pack(s1_sign_q, 8'(FP_EXP_MAX), 23'd0);
        end else if (s1_zero_q) begin
            out_result_d = fp_pack(s1_sign_q, 8'd0, 23'd0);
        end else if ($signed(exp_rnd_s) >= $signed(EXP_TOP)) begin
            out_result_d         = fp_pack(s1_sign_q, 8'(FP_EXP_MAX), 23'd0);
            out_flags_d[FLG_OVF] = 1'b1;
        end else if ($signed(exp_rnd_s) <= 12'sd0) begin
            out_result_d         = fp_pack(s1_sign_q, 8'd0, 23'd0);
            out_flags_d[FLG_UDF] = 1'b1;
        end else begin
            out_result_d = fp_pack(s1_sign_q, exp_rnd_s[7:0], frac_s);
        end
    end

    // Output register: holds while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_result_q <= BITS'(32'd0);
            out_flags_q  <= 3'b000;
        end else if (s2_en_s) begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                out_result_q <= out_result_d;
                out_flags_q  <= out_flags_d;
            end
        end
    end

    // Sticky flags: a clear coinciding with a transfer keeps only that result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_q <= 3'b000;
        end else if (xfer_s) begin
            sticky_q <= flag_clr ? out_flags_q : (sticky_q | out_flags_q);
        end else if (flag_clr) begin
            sticky_q <= 3'b000;
        end
    end

endmodule
